fifo_dpram_pipe: RTL and testbench
==================================

Name: fifo_dpram_pipe

Overview:
- Next-generation single-clock dual-port storage array for the FIFO family: one write port, one read port, same clock.
- Adds the following over the plain array:
  - byte-lane write enables
  - registered read pipeline of selectable depth, with a valid flag
  - defined read-during-write behaviour
  - optional zero-fill of the whole array after reset
- Sits under the FIFO pointer/flag logic; the FIFO controller owns full/empty, and this block owns data storage and read timing.

Parameters:
- ADDR_WIDTH, 3, address bits; DEPTH = 2**ADDR_WIDTH entries
- DATA_WIDTH, 32, word width; must be a multiple of 8
- RD_LATENCY, 1, cycles from ren to rvalid; legal values 1 or 2
- RDW_MODE, 0, same-address read/write in one cycle: 0 = read-first (old data), 1 = write-first (new data)
- CLEAR_ON_RESET, 1, 1 = sweep array to zero after reset; 0 = no sweep

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- init_busy  out  1  high while the clear sweep runs; ports ignored while high
- wen  in  1  write strobe
- wbe  in  DATA_WIDTH/8  byte-lane enables; bit i covers wdata[8i+7:8i]
- waddr  in  ADDR_WIDTH  write address
- wdata  in  DATA_WIDTH  write data
- ren  in  1  read strobe
- raddr  in  ADDR_WIDTH  read address
- rvalid  out  1  rdata carries the result of a ren issued RD_LATENCY cycles earlier
- rdata  out  DATA_WIDTH  read data; holds last value while rvalid is low

Behaviour:
- Reset (rst_n low at a clock edge):
  - rvalid = 0 and rdata = 0; all pipeline stages flushed
  - clear address counter = 0
  - FSM enters CLEAR if CLEAR_ON_RESET = 1, otherwise READY
  - init_busy = 1 when in CLEAR, 0 when in READY
- FSM states:
  - CLEAR: writes zero to address clr_addr each cycle while rst_n is high, then clr_addr increments. When clr_addr = DEPTH-1 is written, FSM moves to READY; init_busy falls on the next edge. With rst_n released at edge 0, init_busy is high for exactly DEPTH cycles.
  - READY: normal operation; no exit except reset.
- In CLEAR:
  - wen and ren are ignored; rvalid stays 0.
  - Reset asserted mid-sweep restarts the sweep at address 0.
- Write (READY, wen = 1 at edge): each lane i with wbe[i] = 1 is updated. Lanes with wbe = 0 keep their old value. wen with wbe = 0 is a no-op.
- Read (READY, ren = 1 at edge t):
  - array word is captured into stage 1
  - RD_LATENCY = 1: rdata/rvalid update at edge t+1
  - RD_LATENCY = 2: one more register stage, so rdata/rvalid update at edge t+2
- Read throughput: back-to-back reads are accepted every cycle with no bubbles. rvalid is a pure delayed copy of the accepted ren.
- Same-address collision (wen and ren to the same address in one cycle):
  - RDW_MODE = 0: read returns the pre-write word.
  - RDW_MODE = 1: read returns the word with the written lanes replaced (wbe-merged bypass).
- Different-address simultaneous read and write: independent, no interaction.
- Addresses are ADDR_WIDTH bits; no out-of-range case exists, and callers wrap pointers modulo DEPTH.
- Illegal RD_LATENCY (anything other than 1 or 2) stops elaboration via a static check.

Optional Feature:
- Macro FIFO_DPRAM_PARITY_EN.
- When defined:
  - each byte lane stores an extra even-parity bit computed from wdata on write; the clear sweep writes parity 0
  - on read, parity is recomputed and compared
  - new output port par_err (DATA_WIDTH/8 bits) is aligned with rdata, valid only when rvalid = 1, and is 0 at reset
  - a single-bit flip injected into the storage array flags exactly the affected lane
- When not defined: no parity storage, no par_err port, and array width is DATA_WIDTH.

Decomposition:
- Shared package fifo_pkg holds:
  - enum for FSM states (CLEAR, READY)
  - localparams for RDW_READ_FIRST = 0 and RDW_WRITE_FIRST = 1
  - function for byte-lane merge (old, new, wbe)
  - function for per-byte parity
- One sub-module, fifo_dpram_core: the bare storage array with a byte-enabled write and an asynchronous read. The top level wraps it with the clear FSM, collision bypass and read pipeline.

Test Plan:
- Clear sweep: ADDR_WIDTH = 3; release rst_n → init_busy high exactly 8 cycles, then 0. Reading addresses 0..7 returns 0x00000000 with rvalid one cycle after each ren.
- Byte enables: write 0xAABBCCDD to addr 2 with wbe = 4'b1111, then 0x11223344 with wbe = 4'b0101 → reading addr 2 returns 0xAA22CC44.
- Latency: RD_LATENCY = 2; ren on cycles 10, 11, 12 for addrs 1, 2, 3 → rvalid high on cycles 12, 13, 14 with the matching data; rdata holds addr-3 data afterwards while rvalid = 0.
- Collision: addr 5 holds 0x0; same-cycle write 0xDEADBEEF with full wbe and read of addr 5 → RDW_MODE = 0 returns 0x0, RDW_MODE = 1 returns 0xDEADBEEF.
- Reset mid-sweep: assert rst_n low at sweep address 4 → init_busy stays high and the sweep restarts at 0; a ren issued during init_busy yields no rvalid.
- Parity (FIFO_DPRAM_PARITY_EN): write 0x01020304, force-flip bit 9 in the array, read → par_err = 4'b0010 with rvalid = 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO dual-port storage family.
// Holds the clear-FSM state enum, read-during-write mode codes, lane merge and parity helpers.
package fifo_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } fsm_state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  function automatic logic [7:0] lane_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
    return be ? new_b : old_b;
  endfunction

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/fifo_dpram_core.sv
// Bare storage array: byte-enabled synchronous write, asynchronous read.
// With FIFO_DPRAM_PARITY_EN defined, one parity bit per byte lane is stored alongside the data.
module fifo_dpram_core #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic [ADDR_WIDTH-1:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
`ifdef FIFO_DPRAM_PARITY_EN
  input  logic [DATA_WIDTH/8-1:0] i_wpar,
  output logic [DATA_WIDTH/8-1:0] o_rpar,
`endif
  input  logic [ADDR_WIDTH-1:0]   i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int NLANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < NLANES; i++) begin
        if (i_be[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

`ifdef FIFO_DPRAM_PARITY_EN
  logic [NLANES-1:0] r_par [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < NLANES; i++) begin
        if (i_be[i]) r_par[i_waddr][i] <= i_wpar[i];
      end
    end
  end

  assign o_rpar = r_par[i_raddr];
`endif

endmodule

// File: rtl/fifo_dpram_pipe.sv
// Single-clock dual-port FIFO storage with post-reset clear sweep, RDW bypass and 1/2-stage read pipe.
// Optional per-lane even parity with par_err output when FIFO_DPRAM_PARITY_EN is defined.
module fifo_dpram_pipe
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH     = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    init_busy,
  input  logic                    wen,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    ren,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   rdata
`ifdef FIFO_DPRAM_PARITY_EN
  ,
  output logic [DATA_WIDTH/8-1:0] par_err
`endif
);

  localparam int NLANES = DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  generate
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("fifo_dpram_pipe: RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("fifo_dpram_pipe: DATA_WIDTH must be a multiple of 8");
    end
  endgenerate

  fsm_state_e            r_state;
  fsm_state_e            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic                  w_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR) r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == CLEAR && r_clr_addr == LAST_ADDR) w_state_nxt = READY;
  end

  assign w_busy    = (r_state == CLEAR);
  assign init_busy = w_busy;

  // The sweep owns the write port; user strobes only count once READY and out of reset.
  logic                  w_wen_acc;
  logic                  w_ren_acc;
  logic                  w_we;
  logic [NLANES-1:0]     w_be;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_collide;

  assign w_wen_acc = rst_n & ~w_busy & wen;
  assign w_ren_acc = rst_n & ~w_busy & ren;
  assign w_we      = w_wen_acc | (rst_n & w_busy);
  assign w_be      = w_busy ? '1 : wbe;
  assign w_waddr   = w_busy ? r_clr_addr : waddr;
  assign w_wdata   = w_busy ? '0 : wdata;
  assign w_collide = (RDW_MODE == RDW_WRITE_FIRST) && w_wen_acc && (waddr == raddr);

  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_rd_sel;

`ifdef FIFO_DPRAM_PARITY_EN
  logic [NLANES-1:0] w_wpar;
  logic [NLANES-1:0] w_rd_par;
  logic [NLANES-1:0] w_rd_par_sel;

  always_comb begin
    w_wpar = '0;
    for (int i = 0; i < NLANES; i++) begin
      w_wpar[i] = ~w_busy & byte_parity(wdata[8*i +: 8]);
    end
  end
`endif

  fifo_dpram_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .clk     (clk),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
`ifdef FIFO_DPRAM_PARITY_EN
    .i_wpar  (w_wpar),
    .o_rpar  (w_rd_par),
`endif
    .i_raddr (raddr),
    .o_rdata (w_rd_word)
  );

  // Write-first collisions forward the written lanes straight into the read path.
  always_comb begin
    w_rd_sel = w_rd_word;
    if (w_collide) begin
      for (int i = 0; i < NLANES; i++) begin
        w_rd_sel[8*i +: 8] = lane_merge(w_rd_word[8*i +: 8], wdata[8*i +: 8], wbe[i]);
      end
    end
  end

`ifdef FIFO_DPRAM_PARITY_EN
  always_comb begin
    w_rd_par_sel = w_rd_par;
    if (w_collide) begin
      for (int i = 0; i < NLANES; i++) begin
        if (wbe[i]) w_rd_par_sel[i] = w_wpar[i];
      end
    end
  end
`endif

  // Stage 1: capture the selected word on an accepted read
  logic                  r_vld_p1;
  logic [DATA_WIDTH-1:0] r_data_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
    end else begin
      r_vld_p1 <= w_ren_acc;
      if (w_ren_acc) r_data_p1 <= w_rd_sel;
    end
  end

`ifdef FIFO_DPRAM_PARITY_EN
  logic [NLANES-1:0] r_par_p1;
  logic [NLANES-1:0] w_par_out;

  always_ff @(posedge clk) begin
    if (!rst_n) r_par_p1 <= '0;
    else if (w_ren_acc) r_par_p1 <= w_rd_par_sel;
  end
`endif

  // Stage 2: optional extra register, advancing only behind a valid stage-1 word
  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  r_vld_p2;
      logic [DATA_WIDTH-1:0] r_data_p2;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_vld_p2  <= 1'b0;
          r_data_p2 <= '0;
        end else begin
          r_vld_p2 <= r_vld_p1;
          if (r_vld_p1) r_data_p2 <= r_data_p1;
        end
      end

      assign rvalid = r_vld_p2;
      assign rdata  = r_data_p2;

`ifdef FIFO_DPRAM_PARITY_EN
      logic [NLANES-1:0] r_par_p2;

      always_ff @(posedge clk) begin
        if (!rst_n) r_par_p2 <= '0;
        else if (r_vld_p1) r_par_p2 <= r_par_p1;
      end

      assign w_par_out = r_par_p2;
`endif
    end else begin : g_lat1
      assign rvalid = r_vld_p1;
      assign rdata  = r_data_p1;
`ifdef FIFO_DPRAM_PARITY_EN
      assign w_par_out = r_par_p1;
`endif
    end
  endgenerate

`ifdef FIFO_DPRAM_PARITY_EN
  always_comb begin
    par_err = '0;
    for (int i = 0; i < NLANES; i++) begin
      par_err[i] = rvalid & (byte_parity(rdata[8*i +: 8]) ^ w_par_out[i]);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_dpram_pipe.sv
// Directed bench for fifo_dpram_pipe: three instances share stimulus (L1/read-first,
// L2/write-first, L1/no-clear) and each scenario task checks hand-computed values.
module tb_fifo_dpram_pipe;

  logic        clk;
  logic        rst_n;
  logic        wen;
  logic [3:0]  wbe;
  logic [2:0]  waddr;
  logic [31:0] wdata;
  logic        ren;
  logic [2:0]  raddr;

  logic        a_busy, b_busy, c_busy;
  logic        a_rvalid, b_rvalid, c_rvalid;
  logic [31:0] a_rdata, b_rdata, c_rdata;
`ifdef FIFO_DPRAM_PARITY_EN
  logic [3:0]  a_perr, b_perr, c_perr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fifo_dpram_pipe #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .init_busy(a_busy), .wen(wen), .wbe(wbe), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rvalid(a_rvalid), .rdata(a_rdata)
`ifdef FIFO_DPRAM_PARITY_EN
    , .par_err(a_perr)
`endif
  );

  fifo_dpram_pipe #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .init_busy(b_busy), .wen(wen), .wbe(wbe), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rvalid(b_rvalid), .rdata(b_rdata)
`ifdef FIFO_DPRAM_PARITY_EN
    , .par_err(b_perr)
`endif
  );

  fifo_dpram_pipe #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .init_busy(c_busy), .wen(wen), .wbe(wbe), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rvalid(c_rvalid), .rdata(c_rdata)
`ifdef FIFO_DPRAM_PARITY_EN
    , .par_err(c_perr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wen = 1'b0; wbe = 4'h0; waddr = '0; wdata = '0; ren = 1'b0; raddr = '0;
    tick; tick;
    n_checks++; if (a_rvalid !== 1'b0) begin $display("FAIL reset_a_rvalid got=%b want=0", a_rvalid); n_fail++; end
    n_checks++; if (a_rdata !== 32'h0) begin $display("FAIL reset_a_rdata got=%h want=00000000", a_rdata); n_fail++; end
    n_checks++; if (a_busy !== 1'b1) begin $display("FAIL reset_a_busy got=%b want=1", a_busy); n_fail++; end
    n_checks++; if (b_busy !== 1'b1) begin $display("FAIL reset_b_busy got=%b want=1", b_busy); n_fail++; end
    n_checks++; if (b_rvalid !== 1'b0) begin $display("FAIL reset_b_rvalid got=%b want=0", b_rvalid); n_fail++; end
    n_checks++; if (c_busy !== 1'b0) begin $display("FAIL reset_c_busy got=%b want=0", c_busy); n_fail++; end
    n_checks++; if (c_rvalid !== 1'b0) begin $display("FAIL reset_c_rvalid got=%b want=0", c_rvalid); n_fail++; end
  endtask

  task automatic test_clear_sweep;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick;
      n_checks++; if (a_busy !== (k < 7)) begin $display("FAIL sweep_a_busy cycle=%0d got=%b want=%b", k, a_busy, (k < 7)); n_fail++; end
      n_checks++; if (b_busy !== (k < 7)) begin $display("FAIL sweep_b_busy cycle=%0d got=%b want=%b", k, b_busy, (k < 7)); n_fail++; end
    end
    n_checks++; if (c_busy !== 1'b0) begin $display("FAIL sweep_c_busy got=%b want=0", c_busy); n_fail++; end
    for (int i = 0; i < 8; i++) begin
      ren = 1'b1; raddr = 3'(i);
      tick;
      n_checks++; if (a_rvalid !== 1'b1) begin $display("FAIL sweep_read_valid addr=%0d got=%b want=1", i, a_rvalid); n_fail++; end
      n_checks++; if (a_rdata !== 32'h0) begin $display("FAIL sweep_read_data addr=%0d got=%h want=00000000", i, a_rdata); n_fail++; end
    end
    ren = 1'b0;
    tick;
    n_checks++; if (a_rvalid !== 1'b0) begin $display("FAIL sweep_a_idle got=%b want=0", a_rvalid); n_fail++; end
    n_checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h0) begin $display("FAIL sweep_b_last got=%b/%h want=1/00000000", b_rvalid, b_rdata); n_fail++; end
    tick;
    n_checks++; if (b_rvalid !== 1'b0) begin $display("FAIL sweep_b_idle got=%b want=0", b_rvalid); n_fail++; end
  endtask

  task automatic test_byte_enables;
    wen = 1'b1; waddr = 3'd2; wbe = 4'b1111; wdata = 32'hAABBCCDD;
    tick;
    wbe = 4'b0101; wdata = 32'h11223344;
    tick;
    wen = 1'b0; ren = 1'b1; raddr = 3'd2;
    tick;
    ren = 1'b0;
    n_checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hAA22CC44) begin $display("FAIL be_merge_a got=%b/%h want=1/aa22cc44", a_rvalid, a_rdata); n_fail++; end
    n_checks++; if (b_rvalid !== 1'b0) begin $display("FAIL be_b_early got=%b want=0", b_rvalid); n_fail++; end
    tick;
    n_checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'hAA22CC44) begin $display("FAIL be_merge_b got=%b/%h want=1/aa22cc44", b_rvalid, b_rdata); n_fail++; end
    n_checks++; if (a_rvalid !== 1'b0 || a_rdata !== 32'hAA22CC44) begin $display("FAIL be_a_hold got=%b/%h want=0/aa22cc44", a_rvalid, a_rdata); n_fail++; end
  endtask

  task automatic test_latency;
    logic        exp_av [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] exp_ad [6] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h33333333, 32'h33333333, 32'h33333333};
    logic        exp_bv [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] exp_bd [6] = '{32'hAA22CC44, 32'h11111111, 32'h22222222, 32'h33333333, 32'h33333333, 32'h33333333};
    wen = 1'b1; wbe = 4'b1111;
    for (int i = 1; i <= 3; i++) begin
      waddr = 3'(i); wdata = 32'h11111111 * i;
      tick;
    end
    wen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 3) begin ren = 1'b1; raddr = 3'(k + 1); end
      else ren = 1'b0;
      tick;
      n_checks++; if (a_rvalid !== exp_av[k] || a_rdata !== exp_ad[k]) begin $display("FAIL lat1 cycle=%0d got=%b/%h want=%b/%h", k, a_rvalid, a_rdata, exp_av[k], exp_ad[k]); n_fail++; end
      n_checks++; if (b_rvalid !== exp_bv[k] || b_rdata !== exp_bd[k]) begin $display("FAIL lat2 cycle=%0d got=%b/%h want=%b/%h", k, b_rvalid, b_rdata, exp_bv[k], exp_bd[k]); n_fail++; end
    end
  endtask

  task automatic test_collision;
    wen = 1'b1; waddr = 3'd5; wbe = 4'b1111; wdata = 32'hDEADBEEF; ren = 1'b1; raddr = 3'd5;
    tick;
    n_checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h0) begin $display("FAIL rdw_read_first got=%b/%h want=1/00000000", a_rvalid, a_rdata); n_fail++; end
    wbe = 4'b0011; wdata = 32'h12345678;
    tick;
    n_checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'hDEADBEEF) begin $display("FAIL rdw_write_first got=%b/%h want=1/deadbeef", b_rvalid, b_rdata); n_fail++; end
    n_checks++; if (a_rdata !== 32'hDEADBEEF) begin $display("FAIL rdw_read_first_2 got=%h want=deadbeef", a_rdata); n_fail++; end
    waddr = 3'd6; wbe = 4'b1111; wdata = 32'hCAFEF00D; raddr = 3'd5;
    tick;
    n_checks++; if (b_rdata !== 32'hDEAD5678) begin $display("FAIL rdw_partial_bypass got=%h want=dead5678", b_rdata); n_fail++; end
    n_checks++; if (a_rdata !== 32'hDEAD5678) begin $display("FAIL diff_addr_a got=%h want=dead5678", a_rdata); n_fail++; end
    waddr = 3'd5; wbe = 4'b0000; wdata = 32'hFFFFFFFF; raddr = 3'd6;
    tick;
    n_checks++; if (b_rdata !== 32'hDEAD5678) begin $display("FAIL diff_addr_b got=%h want=dead5678", b_rdata); n_fail++; end
    n_checks++; if (a_rdata !== 32'hCAFEF00D) begin $display("FAIL diff_addr_write_a got=%h want=cafef00d", a_rdata); n_fail++; end
    wen = 1'b0; raddr = 3'd5;
    tick;
    n_checks++; if (a_rdata !== 32'hDEAD5678) begin $display("FAIL wbe_zero_noop got=%h want=dead5678", a_rdata); n_fail++; end
    n_checks++; if (b_rdata !== 32'hCAFEF00D) begin $display("FAIL diff_addr_write_b got=%h want=cafef00d", b_rdata); n_fail++; end
    ren = 1'b0;
    tick;
    n_checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b1 || b_rdata !== 32'hDEAD5678) begin $display("FAIL coll_tail got=%b/%b/%h want=0/1/dead5678", a_rvalid, b_rvalid, b_rdata); n_fail++; end
    tick;
  endtask

  task automatic test_reset_mid_sweep;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      n_checks++; if (a_busy !== 1'b1) begin $display("FAIL mid_first_pass cycle=%0d got=%b want=1", k, a_busy); n_fail++; end
    end
    rst_n = 1'b0; ren = 1'b1; raddr = 3'd2;
    tick;
    n_checks++; if (a_busy !== 1'b1 || a_rvalid !== 1'b0 || a_rdata !== 32'h0) begin $display("FAIL mid_reset got=%b/%b/%h want=1/0/00000000", a_busy, a_rvalid, a_rdata); n_fail++; end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick;
      n_checks++; if (a_busy !== (k < 7)) begin $display("FAIL mid_restart_busy cycle=%0d got=%b want=%b", k, a_busy, (k < 7)); n_fail++; end
      n_checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin $display("FAIL mid_ren_ignored cycle=%0d got=%b/%b want=0/0", k, a_rvalid, b_rvalid); n_fail++; end
    end
    tick;
    ren = 1'b0;
    n_checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h0) begin $display("FAIL mid_cleared got=%b/%h want=1/00000000", a_rvalid, a_rdata); n_fail++; end
    n_checks++; if (c_busy !== 1'b0) begin $display("FAIL mid_c_busy got=%b want=0", c_busy); n_fail++; end
    tick; tick;
  endtask

`ifdef FIFO_DPRAM_PARITY_EN
  task automatic test_parity;
    wen = 1'b1; waddr = 3'd4; wbe = 4'b1111; wdata = 32'h01020304;
    tick;
    wen = 1'b0; ren = 1'b1; raddr = 3'd4;
    tick;
    ren = 1'b0;
    n_checks++; if (a_rvalid !== 1'b1 || a_perr !== 4'b0000) begin $display("FAIL parity_clean got=%b/%b want=1/0000", a_rvalid, a_perr); n_fail++; end
    dut_a.u_core.r_mem[4][9] = ~dut_a.u_core.r_mem[4][9];
    ren = 1'b1;
    tick;
    ren = 1'b0;
    n_checks++; if (a_rvalid !== 1'b1 || a_perr !== 4'b0010) begin $display("FAIL parity_flip got=%b/%b want=1/0010", a_rvalid, a_perr); n_fail++; end
    tick;
    n_checks++; if (a_perr !== 4'b0000) begin $display("FAIL parity_gated got=%b want=0000", a_perr); n_fail++; end
  endtask
`endif

  initial begin
    test_reset;
    test_clear_sweep;
    test_byte_enables;
    test_latency;
    test_collision;
    test_reset_mid_sweep;
`ifdef FIFO_DPRAM_PARITY_EN
    test_parity;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
